// File: rtl/psum_accumulator.sv
// Partial-sum read-modify-write controller for the conv output buffer.
// Aligns buffer read data with delayed MAC beats, saturating-adds per lane, writes back.
`ifndef MAC_OUTPUT_WIDTH
`define MAC_OUTPUT_WIDTH 36
`endif

module psum_accumulator #(
    parameter int unsigned MAC_OUTPUT_WIDTH = `MAC_OUTPUT_WIDTH,
    parameter int unsigned READ_LATENCY     = 3,
    parameter int unsigned ADDR_WIDTH       = 15
) (
    input  logic                            system_clk,
    input  logic                            rst,
    input  logic                            pass_start,
    input  logic                            first_pass,
    input  logic                            last_pass,
    output logic                            busy,
    input  logic [8*MAC_OUTPUT_WIDTH-1:0]   mac_data,
    input  logic                            mac_valid,
    input  logic                            mac_last,
    output logic                            mac_ready,
    output logic                            refresh_req,
    output logic                            adder_pulse,
    input  logic [8*MAC_OUTPUT_WIDTH-1:0]   adder_feature,
    output logic [8*MAC_OUTPUT_WIDTH-1:0]   feature_in,
    output logic                            feature_valid,
    output logic [8*MAC_OUTPUT_WIDTH-1:0]   result_data,
    output logic                            result_valid,
    output logic                            pass_done,
    output logic                            sat_flag,
    output logic                            depth_err
);

    localparam int unsigned W       = MAC_OUTPUT_WIDTH;
    localparam int unsigned LANES   = 8;
    localparam int unsigned BUS_W   = LANES * W;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned DRAIN_W = $clog2(READ_LATENCY + 2);

    localparam logic [CNT_W-1:0] DEPTH_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [W-1:0]     SAT_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SAT_MIN     = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFRESH,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start_c;
    logic               accept_c;
    logic               first_q;
    logic               last_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [CNT_W-1:0]   beat_cnt;

    logic [BUS_W-1:0]        data_pipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_pipe;
    logic [READ_LATENCY-1:0] last_pipe;
    logic [BUS_W-1:0]        tap_data;
    logic                    tap_valid;
    logic                    tap_last;

    logic [W-1:0]     mac_l;
    logic [W-1:0]     old_l;
    logic [W:0]       wide_l;
    logic [BUS_W-1:0] sum_c;
    logic             sat_any_c;

    // Next-state and accept decode
    always_comb begin
        state_nxt   = state;
        start_c     = 1'b0;
        accept_c    = 1'b0;
        adder_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (pass_start) begin
                    start_c   = 1'b1;
                    state_nxt = S_REFRESH;
                end
            end
            S_REFRESH: state_nxt = S_RUN;
            S_RUN: begin
                accept_c    = mac_valid;
                adder_pulse = mac_valid & ~first_q;
                if (mac_valid && mac_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_W'(READ_LATENCY)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            mac_ready   <= 1'b0;
            refresh_req <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            drain_cnt   <= '0;
            beat_cnt    <= '0;
            depth_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != S_IDLE);
            mac_ready   <= (state_nxt == S_RUN);
            refresh_req <= (state_nxt == S_REFRESH);
            drain_cnt   <= (state == S_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            if (start_c) begin
                first_q   <= first_pass;
                last_q    <= last_pass;
                beat_cnt  <= '0;
                depth_err <= 1'b0;
            end else if (accept_c) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (beat_cnt == DEPTH_LIMIT) begin
                    depth_err <= 1'b1;
                end
            end
        end
    end

    // Delay accepted beats to meet the buffer read data
    always_ff @(posedge system_clk) begin
        if (rst) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_pipe[i] <= '0;
            end
        end else begin
            data_pipe[0]  <= mac_data;
            valid_pipe[0] <= accept_c;
            last_pipe[0]  <= accept_c & mac_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                data_pipe[i]  <= data_pipe[i-1];
                valid_pipe[i] <= valid_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
            end
        end
    end

    assign tap_data  = data_pipe[READ_LATENCY-1];
    assign tap_valid = valid_pipe[READ_LATENCY-1];
    assign tap_last  = last_pipe[READ_LATENCY-1];

    // Lane-wise signed add with saturation; first pass ignores stale buffer data
    always_comb begin
        mac_l     = '0;
        old_l     = '0;
        wide_l    = '0;
        sum_c     = '0;
        sat_any_c = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            mac_l  = tap_data[l*W +: W];
            old_l  = adder_feature[l*W +: W];
            wide_l = {mac_l[W-1], mac_l} + (first_q ? {(W+1){1'b0}} : {old_l[W-1], old_l});
            if (wide_l[W] != wide_l[W-1]) begin
                sum_c[l*W +: W] = wide_l[W] ? SAT_MIN : SAT_MAX;
                sat_any_c       = 1'b1;
            end else begin
                sum_c[l*W +: W] = wide_l[W-1:0];
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            feature_in    <= '0;
            feature_valid <= 1'b0;
            result_data   <= '0;
            result_valid  <= 1'b0;
            pass_done     <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            feature_valid <= tap_valid;
            result_valid  <= tap_valid & last_q;
            pass_done     <= tap_valid & tap_last;
            if (tap_valid) begin
                feature_in  <= sum_c;
                result_data <= sum_c;
            end
            if (start_c) begin
                sat_flag <= 1'b0;
            end else if (tap_valid && sat_any_c) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Read-modify-write controller on the far side of the conv output buffer (partial-sum store).
- Streams 8-lane MAC results in and drives the buffer's refresh_req and adder_pulse.
- Aligns returned adder_feature with the incoming MAC beat, performs a lane-wise saturating add, and writes the sum back through feature_in/feature_valid.
- On the last input-channel pass, also forwards the sums downstream.

Parameters:
- MAC_OUTPUT_WIDTH, `MAC_OUTPUT_WIDTH (36), signed width of one lane; 8 lanes per beat.
- READ_LATENCY, 3, cycles from adder_pulse to valid adder_feature. Set to 3 for the URAM build and 2 for the simulation RAM build.
- ADDR_WIDTH, 15, buffer depth log2; bounds the beats allowed per pass.

Ports:
- system_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pass_start  in  1  pulse: begin a pass; sampled only in IDLE.
- first_pass  in  1  sampled with pass_start; 1 = no prior partial sum.
- last_pass  in  1  sampled with pass_start; 1 = forward sums downstream.
- busy  out  1  high whenever state != IDLE.
- mac_data  in  8*W  MAC results, lane i at [i*W+:W].
- mac_valid  in  1  beat valid.
- mac_last  in  1  final beat of pass, qualified by mac_valid.
- mac_ready  out  1  high only in RUN.
- refresh_req  out  1  to buffer: reset read/write addresses.
- adder_pulse  out  1  to buffer: read-address advance.
- adder_feature  in  8*W  from buffer: prior partial sum.
- feature_in  out  8*W  to buffer: write data.
- feature_valid  out  1  to buffer: write strobe.
- result_data  out  8*W  downstream sum, equal to feature_in.
- result_valid  out  1  feature_valid AND latched last_pass.
- pass_done  out  1  one-cycle pulse when pass is fully written.
- sat_flag  out  1  sticky; set on any lane saturation; cleared at pass_start.
- depth_err  out  1  sticky; set when beat 2^ADDR_WIDTH+1 is accepted; cleared at pass_start.

Behaviour:
- Reset: state=IDLE; all outputs 0, including data buses, flags and counters; pipeline valids cleared.
- Reset asserted mid-pass aborts the pass. No refresh_req is issued; the next pass_start refreshes the buffer.
- States:
  - IDLE: on pass_start, latch first_pass/last_pass, clear sat_flag/depth_err and the beat counter -> REFRESH. pass_start outside IDLE is ignored.
  - REFRESH: refresh_req=1 for exactly one cycle -> RUN.
  - RUN: mac_ready=1. A beat is accepted when mac_valid=1. Accepted beat with mac_last=1 -> DRAIN.
  - DRAIN: count READ_LATENCY+1 cycles -> IDLE. pass_done pulses in the cycle the final feature_valid is asserted, i.e. the last DRAIN cycle.
- adder_pulse = accepted beat AND NOT first_pass_latched, asserted combinationally in the accept cycle. No pulses are issued on a first pass.
- Beat path:
  - mac_data and the accept flag are delayed READ_LATENCY cycles in a shift register.
  - At delay tap READ_LATENCY: sum = first_pass ? mac : mac + adder_feature, lane-wise.
  - The sum is registered one cycle, so feature_valid/feature_in appear exactly READ_LATENCY+1 cycles after accept. This latency is fixed for first and non-first passes.
- Arithmetic:
  - Signed W+1-bit add per lane.
  - Saturate to +(2^(W-1)-1) / -(2^(W-1)).
  - Any saturation sets sat_flag in the same cycle feature_valid is asserted.
- Hazard: each address is read once per pass, and always before it is rewritten, because read leads write by READ_LATENCY+1 cycles. No bypass is required.
- Back-to-back beats with mac_valid held high are accepted every cycle; gaps are allowed and preserve order.
- mac_last asserted on the very first beat is legal: a one-beat pass.
- mac_valid in IDLE, REFRESH or DRAIN is not accepted; no adder_pulse is issued.
- A pass_start arriving in the same cycle that DRAIN -> IDLE is ignored. It is accepted from the next cycle.
- Beat counter is ADDR_WIDTH+1 bits. depth_err is set when a beat is accepted with the counter at 2^ADDR_WIDTH. Data keeps flowing; buffer addresses wrap.

Test Plan:
- First pass, W=36, L=3: pass_start (first=1, last=0), 4 beats of lane value 5 with mac_last on the 4th -> refresh_req at cycle 1; zero adder_pulse; feature_valid 4 cycles after each accept carrying 5; pass_done with the 4th write.
- Accumulate pass: buffer model returns 10 per lane, mac=7, first=0, last=1 -> adder_pulse per beat; feature_in=17 and result_valid=1 exactly 4 cycles after each accept.
- Saturation: adder_feature lane3 = 2^35-1, mac lane3 = 1 -> lane3 output 2^35-1, other lanes unaffected, sat_flag=1 until the next pass_start.
- Gapped stream: mac_valid pattern 1,0,0,1,1 with mac_last on the last beat -> 3 pulses; writes in order at accept+4; buffer write addresses 0,1,2.
- Reset mid-RUN after 2 beats -> next cycle all outputs 0, state IDLE; new pass issues refresh_req, and a follow-up pass reads from address 0.
- Depth, ADDR_WIDTH=2: 5 beats -> depth_err rises on the 5th accept; 5 writes still issued.
